// File: rtl/ps2_paint_cursor_ctrl.sv
// rtl/ps2_paint_cursor_ctrl.sv - PS/2 mouse packet to clamped cursor and framebuffer write sequencer
module ps2_paint_cursor_ctrl #(
    parameter int X_W         = 6,
    parameter int Y_W         = 6,
    parameter int SCR_W       = 64,
    parameter int SCR_H       = 64,
    parameter int SPEED_SHIFT = 0,
    parameter int COLOR_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_done,
    input  logic                 pkt_valid,
    input  logic [8:0]           mouse_dx,
    input  logic [8:0]           mouse_dy,
    input  logic [2:0]           buttons,
    output logic                 fb_req,
    output logic [X_W+Y_W-1:0]   fb_addr,
    output logic [COLOR_W-1:0]   fb_data,
    input  logic                 fb_ack,
    output logic [X_W-1:0]       cursor_x,
    output logic [Y_W-1:0]       cursor_y,
    output logic [COLOR_W-1:0]   color,
    output logic                 busy,
    output logic                 pkt_drop
);

    typedef enum logic [1:0] {IDLE, MOVE, WRITE, CLEAR} state_t;

    localparam logic [X_W-1:0]     X_LAST   = X_W'(SCR_W - 1);
    localparam logic [Y_W-1:0]     Y_LAST   = Y_W'(SCR_H - 1);
    localparam logic signed [11:0] X_LAST_S = 12'(SCR_W - 1);
    localparam logic signed [11:0] Y_LAST_S = 12'(SCR_H - 1);

    state_t             state, state_next;
    logic [8:0]         dx_q, dy_q;
    logic [2:0]         btn_q;
    logic               prev_mid;
    logic [X_W-1:0]     cx, cx_next, nx_c;
    logic [Y_W-1:0]     cy, cy_next, ny_c;
    logic signed [11:0] dx_ext, dy_ext, nx, ny;
    logic               mid_rise;
    logic [COLOR_W-1:0] color_next;
    logic               clear_last;

    assign busy = (state != IDLE);

    // Cursor arithmetic is done signed and wide enough that a full-scale delta never wraps.
    always_comb begin
        dx_ext = $signed({{3{dx_q[8]}}, dx_q}) >>> SPEED_SHIFT;
        dy_ext = $signed({{3{dy_q[8]}}, dy_q}) >>> SPEED_SHIFT;
        nx     = $signed({{(12-X_W){1'b0}}, cursor_x}) + dx_ext;
        ny     = $signed({{(12-Y_W){1'b0}}, cursor_y}) - dy_ext;

        if (nx[11])
            nx_c = '0;
        else if (nx > X_LAST_S)
            nx_c = X_LAST;
        else
            nx_c = nx[X_W-1:0];

        if (ny[11])
            ny_c = '0;
        else if (ny > Y_LAST_S)
            ny_c = Y_LAST;
        else
            ny_c = ny[Y_W-1:0];

        mid_rise   = btn_q[2] & ~prev_mid;
        color_next = color;
        if (mid_rise)
            color_next = (color == '1) ? COLOR_W'(1) : color + COLOR_W'(1);

        clear_last = (cx == X_LAST) && (cy == Y_LAST);
        if (cx == X_LAST) begin
            cx_next = '0;
            cy_next = cy + Y_W'(1);
        end else begin
            cx_next = cx + X_W'(1);
            cy_next = cy;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pkt_valid && init_done)
                    state_next = MOVE;
            end
            MOVE: begin
                if (btn_q[0] && btn_q[1])
                    state_next = CLEAR;
                else if (btn_q[0] || btn_q[1])
                    state_next = WRITE;
                else
                    state_next = IDLE;
            end
            WRITE: begin
                if (fb_req && fb_ack)
                    state_next = IDLE;
            end
            CLEAR: begin
                if (fb_req && fb_ack && clear_last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor_x <= X_W'(SCR_W / 2);
            cursor_y <= Y_W'(SCR_H / 2);
            color    <= COLOR_W'(1);
            fb_req   <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
            pkt_drop <= 1'b0;
            prev_mid <= 1'b0;
            dx_q     <= '0;
            dy_q     <= '0;
            btn_q    <= '0;
            cx       <= '0;
            cy       <= '0;
        end else begin
            if (pkt_valid && state != IDLE)
                pkt_drop <= 1'b1;

            case (state)
                IDLE: begin
                    if (pkt_valid && init_done) begin
                        dx_q  <= mouse_dx;
                        dy_q  <= mouse_dy;
                        btn_q <= buttons;
                    end
                end
                MOVE: begin
                    cursor_x <= nx_c;
                    cursor_y <= ny_c;
                    color    <= color_next;
                    prev_mid <= btn_q[2];
                    if (btn_q[0] && btn_q[1]) begin
                        fb_req  <= 1'b1;
                        fb_addr <= '0;
                        fb_data <= '0;
                        cx      <= '0;
                        cy      <= '0;
                    end else if (btn_q[0] || btn_q[1]) begin
                        fb_req  <= 1'b1;
                        fb_addr <= {ny_c, nx_c};
                        fb_data <= btn_q[0] ? color_next : '0;
                    end
                end
                WRITE: begin
                    if (fb_ack)
                        fb_req <= 1'b0;
                end
                CLEAR: begin
                    // Request stays high across acks so each acked cycle retires one pixel.
                    if (fb_ack) begin
                        if (clear_last) begin
                            fb_req <= 1'b0;
                        end else begin
                            cx      <= cx_next;
                            cy      <= cy_next;
                            fb_addr <= {cy_next, cx_next};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_paint_cursor_ctrl.sv
// tb/tb_ps2_paint_cursor_ctrl.sv - self-checking bench for ps2_paint_cursor_ctrl
module tb_ps2_paint_cursor_ctrl;

    localparam int X_W = 6, Y_W = 6, SCR_W = 64, SCR_H = 64, SPEED_SHIFT = 0, COLOR_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, init_done, pkt_valid, fb_ack;
    logic [8:0]         mouse_dx, mouse_dy;
    logic [2:0]         buttons;
    logic               fb_req, busy, pkt_drop;
    logic [X_W+Y_W-1:0] fb_addr;
    logic [COLOR_W-1:0] fb_data, color;
    logic [X_W-1:0]     cursor_x;
    logic [Y_W-1:0]     cursor_y;

    ps2_paint_cursor_ctrl #(
        .X_W(X_W), .Y_W(Y_W), .SCR_W(SCR_W), .SCR_H(SCR_H),
        .SPEED_SHIFT(SPEED_SHIFT), .COLOR_W(COLOR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .pkt_valid(pkt_valid),
        .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .buttons(buttons),
        .fb_req(fb_req), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ack(fb_ack),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .color(color),
        .busy(busy), .pkt_drop(pkt_drop)
    );

    int n_pass = 0;
    int n_total = 0;

    int m_x, m_y, m_col, m_prev;

    typedef struct {
        bit         rst;
        logic [8:0] dx, dy;
        logic [2:0] btn;
        int         delay;
        int         ex, ey, ec;
        int         ewr, eaddr, edata;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic model_pkt(input logic [8:0] dx, input logic [8:0] dy, input logic [2:0] btn,
                             output int ex, output int ey, output int ec,
                             output int ewr, output int eaddr, output int edata);
        int sdx, sdy;
        sdx = int'($signed(dx)) >>> SPEED_SHIFT;
        sdy = int'($signed(dy)) >>> SPEED_SHIFT;
        m_x = clampi(m_x + sdx, SCR_W - 1);
        m_y = clampi(m_y - sdy, SCR_H - 1);
        if (btn[2] && m_prev == 0)
            m_col = (m_col == (1 << COLOR_W) - 1) ? 1 : m_col + 1;
        m_prev = btn[2] ? 1 : 0;
        ex    = m_x;
        ey    = m_y;
        ec    = m_col;
        ewr   = (btn[0] != btn[1]) ? 1 : 0;
        eaddr = m_y * SCR_W + m_x;
        edata = btn[0] ? m_col : 0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        pkt_valid = 1'b0;
        fb_ack    = 1'b0;
        init_done = 1'b1;
        mouse_dx  = '0;
        mouse_dy  = '0;
        buttons   = '0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        m_x    = SCR_W / 2;
        m_y    = SCR_H / 2;
        m_col  = 1;
        m_prev = 0;
    endtask

    task automatic send_raw(input logic [8:0] dx, input logic [8:0] dy, input logic [2:0] btn);
        @(negedge clk);
        pkt_valid = 1'b1;
        mouse_dx  = dx;
        mouse_dy  = dy;
        buttons   = btn;
        @(negedge clk);
        pkt_valid = 1'b0;
    endtask

    task automatic do_pkt(input string nm, input logic [8:0] dx, input logic [8:0] dy,
                          input logic [2:0] btn, input int delay,
                          input int ex, input int ey, input int ec,
                          input int ewr, input int eaddr, input int edata);
        int bad;
        send_raw(dx, dy, btn);
        check($sformatf("%s.busy_move", nm), int'(busy), 1);
        @(negedge clk);
        check($sformatf("%s.cursor_x", nm), int'(cursor_x), ex);
        check($sformatf("%s.cursor_y", nm), int'(cursor_y), ey);
        check($sformatf("%s.color", nm), int'(color), ec);
        check($sformatf("%s.fb_req", nm), int'(fb_req), ewr);
        if (ewr != 0) begin
            check($sformatf("%s.fb_addr", nm), int'(fb_addr), eaddr);
            check($sformatf("%s.fb_data", nm), int'(fb_data), edata);
            bad = 0;
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                if (fb_req !== 1'b1 || int'(fb_addr) != eaddr || int'(fb_data) != edata)
                    bad++;
            end
            check($sformatf("%s.hold_unstable_cycles", nm), bad, 0);
            fb_ack = 1'b1;
            @(negedge clk);
            fb_ack = 1'b0;
        end
        check($sformatf("%s.fb_req_after", nm), int'(fb_req), 0);
        check($sformatf("%s.busy_after", nm), int'(busy), 0);
    endtask

    task automatic model_and_do(input string nm, input logic [8:0] dx, input logic [8:0] dy,
                                input logic [2:0] btn, input int delay);
        int ex, ey, ec, ewr, eaddr, edata;
        model_pkt(dx, dy, btn, ex, ey, ec, ewr, eaddr, edata);
        do_pkt(nm, dx, dy, btn, delay, ex, ey, ec, ewr, eaddr, edata);
    endtask

    initial begin
        int cnt, bad, hit;
        logic [8:0] rdx, rdy;
        logic [2:0] rbtn;

        vecs[0] = '{1'b1, 9'd5,    9'd3,    3'b000, 0, 37, 29, 1, 0, 0,    0};
        vecs[1] = '{1'b1, 9'h19C,  9'd0,    3'b001, 4, 0,  32, 1, 1, 2048, 1};
        vecs[2] = '{1'b1, 9'h0FF,  9'h101,  3'b010, 2, 63, 63, 1, 1, 4095, 0};
        vecs[3] = '{1'b0, 9'h1FF,  9'd1,    3'b000, 0, 62, 62, 1, 0, 0,    0};
        vecs[4] = '{1'b0, 9'd0,    9'd0,    3'b100, 0, 62, 62, 2, 0, 0,    0};
        vecs[5] = '{1'b0, 9'd0,    9'd0,    3'b101, 1, 62, 62, 2, 1, 4030, 2};
        vecs[6] = '{1'b0, 9'h1C2,  9'd0,    3'b001, 0, 0,  62, 2, 1, 3968, 2};
        vecs[7] = '{1'b0, 9'd3,    9'h1FE,  3'b100, 0, 3,  63, 3, 0, 0,    0};

        rst_n     = 1'b0;
        init_done = 1'b1;
        pkt_valid = 1'b0;
        fb_ack    = 1'b0;
        mouse_dx  = '0;
        mouse_dy  = '0;
        buttons   = '0;
        @(negedge clk);
        check("rst.fb_req", int'(fb_req), 0);
        check("rst.fb_addr", int'(fb_addr), 0);
        check("rst.fb_data", int'(fb_data), 0);
        check("rst.cursor_x", int'(cursor_x), SCR_W / 2);
        check("rst.cursor_y", int'(cursor_y), SCR_H / 2);
        check("rst.color", int'(color), 1);
        check("rst.busy", int'(busy), 0);
        check("rst.pkt_drop", int'(pkt_drop), 0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rst)
                do_reset();
            do_pkt($sformatf("vec%0d", i), vecs[i].dx, vecs[i].dy, vecs[i].btn, vecs[i].delay,
                   vecs[i].ex, vecs[i].ey, vecs[i].ec, vecs[i].ewr, vecs[i].eaddr, vecs[i].edata);
        end
        check("vec.pkt_drop", int'(pkt_drop), 0);

        do_reset();
        for (int i = 0; i < 7; i++)
            model_and_do($sformatf("mid_hold%0d", i), 9'd0, 9'd0, 3'b100, 0);
        check("mid_hold.final_color", int'(color), 2);

        do_reset();
        for (int i = 0; i < 7; i++) begin
            model_and_do($sformatf("mid_alt_press%0d", i), 9'd0, 9'd0, 3'b100, 0);
            check($sformatf("mid_alt_color%0d", i), int'(color), (i + 2 > 7) ? 1 : i + 2);
            model_and_do($sformatf("mid_alt_rel%0d", i), 9'd0, 9'd0, 3'b000, 0);
        end

        do_reset();
        fb_ack = 1'b1;
        send_raw(9'd0, 9'd0, 3'b011);
        cnt = 0;
        bad = 0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            if (fb_req) begin
                if (int'(fb_addr) != cnt || fb_data != '0 || !busy)
                    bad++;
                cnt++;
            end else if (cnt > 0) begin
                break;
            end
            pkt_valid = (cnt == 2000);
            mouse_dx  = 9'd9;
            buttons   = 3'b001;
        end
        pkt_valid = 1'b0;
        fb_ack    = 1'b0;
        check("clear.writes", cnt, SCR_W * SCR_H);
        check("clear.bad_cycles", bad, 0);
        check("clear.busy_after", int'(busy), 0);
        check("clear.pkt_drop", int'(pkt_drop), 1);
        check("clear.cursor_x", int'(cursor_x), 32);
        check("clear.cursor_y", int'(cursor_y), 32);

        do_reset();
        model_and_do("pre_clr_mid", 9'd0, 9'd0, 3'b100, 0);
        fb_ack = 1'b1;
        send_raw(9'd0, 9'd0, 3'b011);
        hit = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            pkt_valid = fb_req && (fb_addr == 12'd50);
            if (fb_req && fb_addr == 12'd100) begin
                hit = 1;
                break;
            end
        end
        pkt_valid = 1'b0;
        check("rstclr.reached_addr100", hit, 1);
        check("rstclr.pkt_drop_before", int'(pkt_drop), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstclr.fb_req", int'(fb_req), 0);
        check("rstclr.busy", int'(busy), 0);
        check("rstclr.cursor_x", int'(cursor_x), 32);
        check("rstclr.cursor_y", int'(cursor_y), 32);
        check("rstclr.color", int'(color), 1);
        check("rstclr.pkt_drop", int'(pkt_drop), 0);
        fb_ack = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        init_done = 1'b0;
        send_raw(9'd5, 9'd3, 3'b001);
        repeat (3) @(negedge clk);
        check("noinit.busy", int'(busy), 0);
        check("noinit.fb_req", int'(fb_req), 0);
        check("noinit.cursor_x", int'(cursor_x), 32);
        check("noinit.cursor_y", int'(cursor_y), 32);
        check("noinit.pkt_drop", int'(pkt_drop), 0);

        do_reset();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                rdx = 9'($urandom_range(0, 511));
                rdy = 9'($urandom_range(0, 511));
            end else begin
                rdx = 9'($signed($urandom_range(0, 16)) - 8);
                rdy = 9'($signed($urandom_range(0, 16)) - 8);
            end
            rbtn = 3'($urandom_range(0, 7));
            if (rbtn[1:0] == 2'b11)
                rbtn[1] = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                fb_ack = 1'b1;
                @(negedge clk);
                fb_ack = 1'b0;
            end
            model_and_do($sformatf("rnd%0d", i), rdx, rdy, rbtn, int'($urandom_range(0, 3)));
        end
        check("rnd.pkt_drop", int'(pkt_drop), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
